// File: rtl/maze_host_ctrl.sv
// maze_host_ctrl: host-side sequencer for a maze solver.
// Each session starts the solver, waits for solve/fail, enables replay while
// counting rat moves, then reports one result.
// Optional watchdog: define MAZE_HOST_TIMEOUT_EN to abort sessions that stall
// in SOLVE/RUN for TIMEOUT_CYCLES clocks.
module maze_host_ctrl #(
  parameter int unsigned COUNT_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               solver_done,
  input  logic               solver_fail,
  input  logic               solver_move,
  output logic               start,
  output logic               run,
  output logic               busy,
  output logic               result_valid,
  output logic               result_found,
  output logic [COUNT_W-1:0] move_count,
  output logic               timeout
);

  localparam int unsigned WD_W = 16;

  // Elaboration-time guard on the watchdog limit
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("maze_host_ctrl: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    SOLVE  = 3'd2,
    RUN    = 3'd3,
    REPORT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               start_q, start_d;
  logic               run_q, run_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               found_q, found_d;
  logic               timeout_q, timeout_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               expire_c;

`ifdef MAZE_HOST_TIMEOUT_EN
  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog fires on the cycle its count would reach the limit
  assign expire_c = ((state_q == SOLVE) || (state_q == RUN)) &&
                    (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end

  // Cleared on entry to SOLVE, counts every SOLVE/RUN cycle
  always_comb begin
    wd_d = wd_q;
    if (state_q == START)
      wd_d = '0;
    else if ((state_q == SOLVE) || (state_q == RUN))
      wd_d = wd_q + WD_W'(1);
  end
`else
  assign expire_c = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      found_q   <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      run_q     <= run_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      found_q   <= found_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  // Next-state, result bookkeeping and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    found_d   = found_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    done_d    = solver_done;

    case (state_q)
      IDLE: begin
        if (go) begin
          count_d   = '0;
          found_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        state_d = SOLVE;
      end
      SOLVE: begin
        if (expire_c) begin
          timeout_d = 1'b1;
          found_d   = 1'b0;
          state_d   = REPORT;
        end else if (solver_fail) begin
          found_d = 1'b0;
          state_d = REPORT;
        end else if (solver_done) begin
          // Mask the still-high done level so only a fresh edge ends replay
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (solver_move && (count_q != {COUNT_W{1'b1}}))
          count_d = count_q + COUNT_W'(1);
        if (expire_c) begin
          timeout_d = 1'b1;
          found_d   = 1'b0;
          state_d   = REPORT;
        end else if (solver_done && !done_q) begin
          found_d = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    start_d = (state_d == START);
    run_d   = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == REPORT);
  end

  assign start        = start_q;
  assign run          = run_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result_found = found_q;
  assign move_count   = count_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_maze_host_ctrl.sv
// Directed bench for maze_host_ctrl: default instance, a COUNT_W=3 instance
// sharing its stimulus, and a TIMEOUT_CYCLES=20 instance for the watchdog.
module tb_maze_host_ctrl;

`ifdef MAZE_HOST_TIMEOUT_EN
  localparam int   EXP_HIT = 20;
  localparam logic EXP_TO  = 1'b1;
`else
  localparam int   EXP_HIT = 0;
  localparam logic EXP_TO  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0, sdone = 1'b0, sfail = 1'b0, smove = 1'b0;
  logic go_t = 1'b0, fail_t = 1'b0, done_t = 1'b0, move_t = 1'b0;

  logic       start, run, busy, rv, found, tmo;
  logic [7:0] mc;
  logic       start_s, run_s, busy_s, rv_s, found_s, tmo_s;
  logic [2:0] mc_s;
  logic       start_t, run_t, busy_t, rv_t, found_t, tmo_t;
  logic [7:0] mc_t;

  int errors = 0;
  int checks = 0;
  int start_hi = 0;
  int rv_cnt = 0;

  always #5 clk = ~clk;

  maze_host_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .solver_done(sdone), .solver_fail(sfail),
    .solver_move(smove), .start(start), .run(run), .busy(busy),
    .result_valid(rv), .result_found(found), .move_count(mc), .timeout(tmo));

  maze_host_ctrl #(.COUNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .go(go), .solver_done(sdone), .solver_fail(sfail),
    .solver_move(smove), .start(start_s), .run(run_s), .busy(busy_s),
    .result_valid(rv_s), .result_found(found_s), .move_count(mc_s), .timeout(tmo_s));

  maze_host_ctrl #(.TIMEOUT_CYCLES(20)) dut_t (
    .clk(clk), .rst(rst), .go(go_t), .solver_done(done_t), .solver_fail(fail_t),
    .solver_move(move_t), .start(start_t), .run(run_t), .busy(busy_t),
    .result_valid(rv_t), .result_found(found_t), .move_count(mc_t), .timeout(tmo_t));

  // Pulse counters for the default instance, sampled mid-cycle
  always @(negedge clk) begin
    if (start === 1'b1) start_hi++;
    if (rv === 1'b1)    rv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({start, run, busy, rv, found, tmo} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {start, run, busy, rv, found, tmo}); end
    checks++; if (mc !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", mc); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if ({busy, busy_s, busy_t} !== 3'b0) begin errors++; $display("FAIL reset_idle: got %b want 000", {busy, busy_s, busy_t}); end
  endtask

  task automatic test_solve_replay();
    int s0, r0;
    logic run_ok;
    s0 = start_hi; r0 = rv_cnt; run_ok = 1'b1;
    go = 1'b1; tick(); go = 1'b0;
    checks++; if ({start, busy, run} !== 3'b110) begin errors++; $display("FAIL sr_start: got start,busy,run=%b want 110", {start, busy, run}); end
    repeat (10) tick();
    checks++; if ({start, run, busy} !== 3'b001) begin errors++; $display("FAIL sr_solve: got start,run,busy=%b want 001", {start, run, busy}); end
    sdone = 1'b1; tick(); sdone = 1'b0;
    if (run !== 1'b1) run_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smove = 1'b1; tick();
      if (run !== 1'b1) run_ok = 1'b0;
    end
    smove = 1'b0; tick();
    if (run !== 1'b1) run_ok = 1'b0;
    checks++; if (run_ok !== 1'b1) begin errors++; $display("FAIL sr_run_held: got %b want 1", run_ok); end
    sdone = 1'b1; tick(); sdone = 1'b0;
    checks++; if ({rv, found, tmo, run} !== 4'b1100) begin errors++; $display("FAIL sr_report: got rv,found,timeout,run=%b want 1100", {rv, found, tmo, run}); end
    checks++; if (mc !== 8'd5) begin errors++; $display("FAIL sr_count: got %0d want 5", mc); end
    checks++; if (mc_s !== 3'd5) begin errors++; $display("FAIL sr_count_w3: got %0d want 5", mc_s); end
    repeat (4) tick();
    checks++; if ({rv, busy, found} !== 3'b001 || mc !== 8'd5) begin errors++; $display("FAIL sr_hold: got rv,busy,found=%b count=%0d want 001 count=5", {rv, busy, found}, mc); end
    checks++; if (start_hi - s0 !== 1) begin errors++; $display("FAIL sr_start_cycles: got %0d want 1", start_hi - s0); end
    checks++; if (rv_cnt - r0 !== 1) begin errors++; $display("FAIL sr_valid_pulses: got %0d want 1", rv_cnt - r0); end
  endtask

  task automatic test_fail();
    logic run_seen;
    run_seen = 1'b0;
    go = 1'b1; tick(); go = 1'b0; tick();
    repeat (7) begin tick(); if (run !== 1'b0) run_seen = 1'b1; end
    sfail = 1'b1; tick(); sfail = 1'b0;
    if (run !== 1'b0) run_seen = 1'b1;
    checks++; if ({rv, found} !== 2'b10 || mc !== 8'd0) begin errors++; $display("FAIL fail_report: got rv,found=%b count=%0d want 10 count=0", {rv, found}, mc); end
    checks++; if (run_seen !== 1'b0) begin errors++; $display("FAIL fail_run: got run_seen=%b want 0", run_seen); end
    tick();
  endtask

  task automatic test_fail_wins();
    go = 1'b1; tick(); go = 1'b0; tick(); tick();
    sdone = 1'b1; sfail = 1'b1; tick(); sdone = 1'b0; sfail = 1'b0;
    checks++; if ({rv, found, run} !== 3'b100) begin errors++; $display("FAIL both_report: got rv,found,run=%b want 100", {rv, found, run}); end
    tick();
  endtask

  task automatic test_saturate();
    go = 1'b1; tick(); go = 1'b0; tick();
    sdone = 1'b1; tick(); sdone = 1'b0;
    smove = 1'b1; repeat (10) tick(); smove = 1'b0; tick();
    sdone = 1'b1; tick(); sdone = 1'b0;
    checks++; if (mc_s !== 3'd7 || rv_s !== 1'b1) begin errors++; $display("FAIL sat_w3: got count=%0d rv=%b want count=7 rv=1", mc_s, rv_s); end
    checks++; if (mc !== 8'd10) begin errors++; $display("FAIL sat_w8: got %0d want 10", mc); end
    tick();
  endtask

  task automatic test_back_to_back();
    go = 1'b1; tick(); go = 1'b0; tick();
    smove = 1'b1; tick(); smove = 1'b0;
    go = 1'b1; tick(); go = 1'b0;
    checks++; if (start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL go_ignored: got start=%b busy=%b want 0 1", start, busy); end
    sdone = 1'b1; tick(); sdone = 1'b0;
    smove = 1'b1; repeat (3) tick();
    sdone = 1'b1; tick(); sdone = 1'b0; smove = 1'b0;
    checks++; if (mc !== 8'd4 || found !== 1'b1) begin errors++; $display("FAIL move_on_edge: got count=%0d found=%b want 4 1", mc, found); end
    tick();
    smove = 1'b1; tick(); smove = 1'b0; tick();
    checks++; if (mc !== 8'd4) begin errors++; $display("FAIL move_idle: got %0d want 4", mc); end
  endtask

  task automatic test_reset_mid_run();
    int r0;
    go = 1'b1; tick(); go = 1'b0; tick();
    sdone = 1'b1; tick(); sdone = 1'b0;
    smove = 1'b1; tick(); smove = 1'b0;
    r0 = rv_cnt;
    #3 rst = 1'b1;
    #1;
    checks++; if ({run, busy, start} !== 3'b000) begin errors++; $display("FAIL rst_async: got run,busy,start=%b want 000", {run, busy, start}); end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (rv_cnt !== r0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_result: got pulses=%0d busy=%b want %0d 0", rv_cnt, busy, r0); end
    go = 1'b1; tick(); go = 1'b0;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL rst_restart: got start=%b want 1", start); end
    tick(); sfail = 1'b1; tick(); sfail = 1'b0;
    checks++; if ({rv, found, tmo} !== 3'b100 || mc !== 8'd0) begin errors++; $display("FAIL rst_clean: got rv,found,timeout=%b count=%0d want 100 0", {rv, found, tmo}, mc); end
    tick();
  endtask

  task automatic test_watchdog();
    int hit;
    hit = 0;
    go_t = 1'b1; tick(); go_t = 1'b0; tick();
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (hit == 0 && rv_t === 1'b1) hit = i;
    end
    checks++; if (hit !== EXP_HIT) begin errors++; $display("FAIL wd_latency: got %0d want %0d", hit, EXP_HIT); end
    checks++; if (tmo_t !== EXP_TO || found_t !== 1'b0 || run_t !== 1'b0) begin errors++; $display("FAIL wd_flags: got timeout=%b found=%b run=%b want %b 0 0", tmo_t, found_t, run_t, EXP_TO); end
    checks++; if (busy_t !== ~EXP_TO) begin errors++; $display("FAIL wd_busy: got %b want %b", busy_t, ~EXP_TO); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL wd_default: got %b want 0", tmo); end
    fail_t = 1'b1; tick(); fail_t = 1'b0; tick();
    checks++; if (busy_t !== 1'b0) begin errors++; $display("FAIL wd_release: got %b want 0", busy_t); end
  endtask

  initial begin
    test_reset();
    test_solve_replay();
    test_fail();
    test_fail_wins();
    test_saturate();
    test_back_to_back();
    test_reset_mid_run();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
